regmap_bram_req_adapter: RTL and testbench
==========================================

Name: regmap_bram_req_adapter

Overview:
- Upstream neighbour of the regmap BRAM width converter.
- Accepts 32-bit register-bus requests from the IOPMP regmap decoder using valid/ready request and response channels.
- Range-checks and aligns each request, converts the byte address to a word index, and issues a single en/we access to the converter.
- Returns read data and error status through a buffered response channel.

Parameters:
- BASE_ADDR, 0, byte address of word 0 of the BRAM window.
- BYTE_ADDR_W, 16, width of the upstream byte address.
- DATA_W, 32, width of the upstream data; equals the converter's narrow output width.
- NUM_WORDS, 128, number of DATA_W words visible in the window; must be a power of 2.
- WORD_ADDR_W, $clog2(NUM_WORDS), width of the word index driven to the converter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  BYTE_ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  DATA_W/8  byte strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_error_o  out  1  request rejected or access failed.
- en_o  out  1  converter enable.
- we_o  out  1  converter write enable.
- addr_o  out  WORD_ADDR_W  converter word index.
- din_o  out  DATA_W  converter write data.
- dout_i  in  DATA_W  converter read data.
- valid_i  in  1  converter read data valid.
- ready_i  in  1  converter can accept an access.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state: FSM in IDLE. rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, en_o=0, we_o=0, addr_o=0, din_o=0. req_ready_o equals ready_i (see IDLE).
- FSM states: IDLE, WAIT, RESP.

Decode (combinational on request inputs):
- off = req_addr_i - BASE_ADDR.
- Request is legal if all hold:
  - req_addr_i >= BASE_ADDR;
  - off < NUM_WORDS*DATA_W/8;
  - off[1:0] == 0;
  - for writes, req_wstrb_i is all ones (no partial writes; the converter merges whole DATA_W words only).
- Word index = off >> 2, truncated to WORD_ADDR_W.

IDLE:
- req_ready_o = ready_i.
- Handshake (req_valid_i & ready_i) on a legal request:
  - en_o=1, we_o=req_write_i, addr_o=index, din_o=req_wdata_i, all combinational in the same cycle.
  - Latch the op type; go to WAIT.
- Handshake on an illegal request:
  - No converter access (en_o stays 0).
  - Register rsp_error_o=1, rsp_rdata_o=0; go to RESP.
- en_o is never asserted while ready_i=0.

WAIT (exactly one cycle; the converter is in its second stage):
- Read:
  - If valid_i=1: register rsp_rdata_o=dout_i, rsp_error_o=0.
  - Otherwise: register rsp_rdata_o=0, rsp_error_o=1 (protocol fault).
- Write: register rsp_rdata_o=0, rsp_error_o=0.
- Go to RESP. req_ready_o=0. en_o=0.

RESP:
- rsp_valid_o=1. rsp_rdata_o and rsp_error_o held stable until rsp_ready_i=1.
- On rsp_valid_o & rsp_ready_i: go to IDLE, clear rsp_rdata_o and rsp_error_o.
- req_ready_o=0 throughout RESP. No new request is accepted in the cycle the response handshakes.

Latency and throughput:
- Accept at cycle T; rsp_valid_o high from T+2 for legal requests, from T+1 for illegal ones.
- At most one outstanding transaction.
- Minimum spacing between accepts is 3 cycles (legal) or 2 cycles (illegal), given rsp_ready_i=1.

Other rules:
- Asserting rst_ni low in WAIT or RESP aborts the transaction and drops the response. A converter write already issued may still complete.
- Request inputs are sampled only at the handshake; their values outside IDLE are ignored.
- Address arithmetic is unsigned, width BYTE_ADDR_W. Underflow of off is caught by the req_addr_i >= BASE_ADDR term.

Test Plan:
- Read hit: BRAM word 5 = 0xDEADBEEF, BASE_ADDR=0, read at addr 0x14 -> en_o=1, we_o=0, addr_o=5 in the accept cycle; rsp_valid_o at T+2 with rsp_rdata_o=0xDEADBEEF, rsp_error_o=0.
- Write then readback: write 0xA5A5_0001 to 0x1FC, wstrb=0xF -> addr_o=127, we_o=1; write response has error=0, rdata=0. A following read of 0x1FC returns 0xA5A5_0001 and the neighbouring words are unchanged.
- Illegal requests:
  - read 0x200 (out of range);
  - read 0x06 (misaligned);
  - write with wstrb=0x3.
  - Each -> en_o stays 0; rsp_valid_o at T+1 with rsp_error_o=1, rsp_rdata_o=0.
- Backpressure:
  - Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stay stable, req_ready_o=0, a pending req_valid_i is not accepted.
  - Hold ready_i=0 in IDLE -> req_ready_o=0 and en_o=0 until ready_i rises.
- Converter fault: force valid_i=0 during the WAIT cycle of a read -> rsp_error_o=1.
- Reset mid-operation: pulse rst_ni low in WAIT, then separately in RESP -> all outputs return to reset values immediately; after release the next read completes normally.

Source files
------------

// File: rtl/regmap_bram_req_adapter.sv
// -----------------------------------------------------------------------------
// regmap_bram_req_adapter
//
// Purpose:
//   Bridges 32-bit register-bus requests from the IOPMP regmap decoder onto the
//   regmap BRAM width converter. Each accepted request is range-checked and
//   alignment-checked against the BRAM window, turned into a single en/we word
//   access, and answered through a buffered response channel. Only one
//   transaction is in flight at a time.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake
//   req_write_i           1 = write, 0 = read
//   req_addr_i            byte address (BYTE_ADDR_W)
//   req_wdata_i           write data (DATA_W)
//   req_wstrb_i           byte strobes; writes must assert every strobe
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data, 0 for writes and errors
//   rsp_error_o           request rejected or converter fault
//   en_o, we_o            converter access enable / write enable
//   addr_o                converter word index (WORD_ADDR_W)
//   din_o                 converter write data
//   dout_i, valid_i       converter read data and its valid flag
//   ready_i               converter can accept an access this cycle
// -----------------------------------------------------------------------------
module regmap_bram_req_adapter #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned BYTE_ADDR_W = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_WORDS   = 128,
  parameter int unsigned WORD_ADDR_W = $clog2(NUM_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [BYTE_ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0]      req_wdata_i,
  input  logic [DATA_W/8-1:0]    req_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_W-1:0]      rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   en_o,
  output logic                   we_o,
  output logic [WORD_ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0]      din_o,
  input  logic [DATA_W-1:0]      dout_i,
  input  logic                   valid_i,
  input  logic                   ready_i
);

  localparam int unsigned            BYTES_PER_WORD = DATA_W / 8;
  localparam int unsigned            OFF_SHIFT      = $clog2(BYTES_PER_WORD);
  localparam logic [63:0]            WINDOW_BYTES   = 64'(NUM_WORDS) * 64'(BYTES_PER_WORD);
  localparam logic [BYTE_ADDR_W-1:0] BASE           = BYTE_ADDR_W'(BASE_ADDR);
  localparam logic [BYTE_ADDR_W-1:0] ALIGN_MASK     = BYTE_ADDR_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                   r_state;
  logic [DATA_W-1:0]        r_rdata;
  logic                     r_error;
  logic                     r_isWrite;

  state_t                   w_nextState;
  logic [DATA_W-1:0]        w_nextRdata;
  logic                     w_nextError;
  logic                     w_nextIsWrite;

  logic [BYTE_ADDR_W-1:0]   w_off;
  logic                     w_inRange;
  logic                     w_aligned;
  logic                     w_fullStrobe;
  logic                     w_legal;
  logic [WORD_ADDR_W-1:0]   w_index;

  // Request decode. The window size is compared in 64 bits so a window that
  // spans the whole byte-address space cannot wrap the comparison; an address
  // below BASE wraps w_off, which the explicit lower-bound term rejects.
  assign w_off        = req_addr_i - BASE;
  assign w_inRange    = (64'(w_off) < WINDOW_BYTES);
  assign w_aligned    = ((w_off & ALIGN_MASK) == '0);
  assign w_fullStrobe = req_write_i ? (&req_wstrb_i) : 1'b1;
  assign w_legal      = (req_addr_i >= BASE) && w_inRange && w_aligned && w_fullStrobe;
  assign w_index      = WORD_ADDR_W'(w_off >> OFF_SHIFT);

  assign rsp_valid_o  = (r_state == S_RESP);
  assign rsp_rdata_o  = r_rdata;
  assign rsp_error_o  = r_error;

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_rdata   <= '0;
      r_error   <= 1'b0;
      r_isWrite <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_rdata   <= w_nextRdata;
      r_error   <= w_nextError;
      r_isWrite <= w_nextIsWrite;
    end
  end

  // Next-state and converter drive. The converter access is issued
  // combinationally in the accept cycle so its two-stage pipeline delivers
  // read data exactly during WAIT; illegal requests skip WAIT entirely.
  always_comb begin
    w_nextState   = r_state;
    w_nextRdata   = r_rdata;
    w_nextError   = r_error;
    w_nextIsWrite = r_isWrite;
    req_ready_o   = 1'b0;
    en_o          = 1'b0;
    we_o          = 1'b0;
    addr_o        = '0;
    din_o         = '0;

    case (r_state)
      S_IDLE: begin
        req_ready_o = ready_i;
        if (req_valid_i && ready_i) begin
          if (w_legal) begin
            en_o          = 1'b1;
            we_o          = req_write_i;
            addr_o        = w_index;
            din_o         = req_wdata_i;
            w_nextIsWrite = req_write_i;
            w_nextState   = S_WAIT;
          end else begin
            w_nextRdata   = '0;
            w_nextError   = 1'b1;
            w_nextState   = S_RESP;
          end
        end
      end

      // A read without valid_i here means the converter broke its fixed
      // latency; report it rather than returning stale data.
      S_WAIT: begin
        if (r_isWrite) begin
          w_nextRdata = '0;
          w_nextError = 1'b0;
        end else if (valid_i) begin
          w_nextRdata = dout_i;
          w_nextError = 1'b0;
        end else begin
          w_nextRdata = '0;
          w_nextError = 1'b1;
        end
        w_nextState = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          w_nextRdata = '0;
          w_nextError = 1'b0;
          w_nextState = S_IDLE;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regmap_bram_req_adapter.sv
// -----------------------------------------------------------------------------
// tb_regmap_bram_req_adapter
//
// Purpose:
//   Self-checking bench for regmap_bram_req_adapter. A small converter model
//   answers en/we accesses with one cycle of read latency. Expected responses
//   are computed from an independent reference memory and legality rule when a
//   request is issued, queued, and compared when the response appears.
// -----------------------------------------------------------------------------
module tb_regmap_bram_req_adapter;

  localparam int DATA_W      = 32;
  localparam int BYTE_ADDR_W = 16;
  localparam int NUM_WORDS   = 128;
  localparam int WORD_ADDR_W = 7;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_write_i;
  logic [BYTE_ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0]      req_wdata_i;
  logic [DATA_W/8-1:0]    req_wstrb_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [DATA_W-1:0]      rsp_rdata_o;
  logic                   rsp_error_o;
  logic                   en_o;
  logic                   we_o;
  logic [WORD_ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0]      din_o;
  logic [DATA_W-1:0]      dout_i  = '0;
  logic                   valid_i = 1'b0;
  logic                   ready_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] convMem[NUM_WORDS];
  logic [31:0] refMem[NUM_WORDS];
  bit          faultNext = 1'b0;
  int          cyc = 0;
  int          checkCount = 0;
  int          passCount = 0;

  regmap_bram_req_adapter #(
    .BASE_ADDR(0), .BYTE_ADDR_W(BYTE_ADDR_W), .DATA_W(DATA_W),
    .NUM_WORDS(NUM_WORDS), .WORD_ADDR_W(WORD_ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .din_o(din_o),
    .dout_i(dout_i), .valid_i(valid_i), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  // Converter model: reads return data one cycle after the access; faultNext
  // suppresses the valid flag to emulate a protocol fault.
  always @(posedge clk_i) begin
    valid_i <= 1'b0;
    if (en_o && ready_i) begin
      if (we_o) convMem[addr_o] <= din_o;
      else begin
        dout_i  <= convMem[addr_o];
        valid_i <= !faultNext;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit isLegal(input bit w, input logic [15:0] a, input logic [3:0] s);
    return (a < 16'h0200) && (a[1:0] == 2'b00) && (!w || s == 4'hF);
  endfunction

  // Drives one request, waits (bounded) for the handshake, samples the
  // converter-side outputs in the accept cycle and queues the expected response.
  task automatic issue(input bit w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc, output logic enS,
                       output logic weS, output logic [6:0] adS,
                       output logic [31:0] dinS, output bit ok);
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a;
    req_wdata_i = d; req_wstrb_i = s;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    acc = cyc; enS = en_o; weS = we_o; adS = addr_o; dinS = din_o;
    if (isLegal(w, a, s)) begin
      e.lat = 2; e.err = 1'b0;
      e.rdata = w ? 32'h0 : refMem[a[8:2]];
      if (w) refMem[a[8:2]] = d;
      if (!w && faultNext) begin e.err = 1'b1; e.rdata = 32'h0; end
    end else begin
      e.lat = 1; e.err = 1'b1; e.rdata = 32'h0;
    end
    if (ok) expQ.push_back(e);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  // Waits (bounded) for a response; returns after the following clock edge,
  // where the handshake completes if rsp_ready_i is high.
  task automatic collect(output bit got, output int rc, output logic [31:0] rd,
                         output logic er);
    got = 1'b0; rc = 0; rd = 32'h0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        got = 1'b1; rc = cyc; rd = rsp_rdata_o; er = rsp_error_o;
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic popExp(output exp_t e, output bit have);
    have = (expQ.size() > 0);
    if (have) e = expQ.pop_front();
    else begin e.rdata = 32'h0; e.err = 1'b0; e.lat = 0; end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ready_i = 1'b1; rsp_ready_i = 1'b1; req_valid_i = 1'b0;
    req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    repeat (3) @(negedge clk_i);
    checkCount++; if (rsp_valid_o !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); else passCount++;
    checkCount++; if (rsp_rdata_o !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", rsp_rdata_o); else passCount++;
    checkCount++; if (rsp_error_o !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", rsp_error_o); else passCount++;
    checkCount++; if ({en_o, we_o} !== 2'b00) $display("[TB] FAIL reset_en_we: got %b expected 00", {en_o, we_o}); else passCount++;
    checkCount++; if ({addr_o, din_o} !== 39'h0) $display("[TB] FAIL reset_addr_din: got %h expected 0", {addr_o, din_o}); else passCount++;
    checkCount++; if (req_ready_o !== 1'b1) $display("[TB] FAIL reset_req_ready_hi: got %b expected 1", req_ready_o); else passCount++;
    ready_i = 1'b0; #1;
    checkCount++; if (req_ready_o !== 1'b0) $display("[TB] FAIL reset_req_ready_lo: got %b expected 0", req_ready_o); else passCount++;
    ready_i = 1'b1;
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    checkCount++; if (rsp_valid_o !== 1'b0) $display("[TB] FAIL post_reset_rsp_valid: got %b expected 0", rsp_valid_o); else passCount++;
  endtask

  task automatic test_read_hit();
    int acc, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    issue(1'b0, 16'h0014, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if (ok !== 1'b1) $display("[TB] FAIL read_hit_accept: got %b expected 1", ok); else passCount++;
    checkCount++; if ({enS, weS, adS} !== {1'b1, 1'b0, 7'd5}) $display("[TB] FAIL read_hit_access: got en/we/addr %b/%b/%0d expected 1/0/5", enS, weS, adS); else passCount++;
    checkCount++; if (got !== 1'b1) $display("[TB] FAIL read_hit_rsp_timeout: got %b expected 1", got); else passCount++;
    checkCount++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL read_hit_rdata: got %h expected DEADBEEF", rd); else passCount++;
    checkCount++; if ({er, rd} !== {e.err, e.rdata}) $display("[TB] FAIL read_hit_scoreboard: got %b/%h expected %b/%h", er, rd, e.err, e.rdata); else passCount++;
    checkCount++; if (rc - acc !== e.lat) $display("[TB] FAIL read_hit_latency: got %0d expected %0d", rc - acc, e.lat); else passCount++;
  endtask

  task automatic test_write_readback();
    int acc, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    logic [15:0] rdAddr [2] = '{16'h01FC, 16'h01F8};
    issue(1'b1, 16'h01FC, 32'hA5A5_0001, 4'hF, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({enS, weS, adS} !== {1'b1, 1'b1, 7'd127}) $display("[TB] FAIL write_access: got en/we/addr %b/%b/%0d expected 1/1/127", enS, weS, adS); else passCount++;
    checkCount++; if (dinS !== 32'hA5A5_0001) $display("[TB] FAIL write_din: got %h expected A5A50001", dinS); else passCount++;
    checkCount++; if ({got, er, rd} !== {1'b1, e.err, e.rdata}) $display("[TB] FAIL write_rsp: got v/e/d %b/%b/%h expected 1/%b/%h", got, er, rd, e.err, e.rdata); else passCount++;
    checkCount++; if (rc - acc !== e.lat) $display("[TB] FAIL write_latency: got %0d expected %0d", rc - acc, e.lat); else passCount++;
    foreach (rdAddr[k]) begin
      issue(1'b0, rdAddr[k], 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
      collect(got, rc, rd, er);
      popExp(e, have);
      checkCount++; if ({have, got, er, rd} !== {1'b1, 1'b1, e.err, e.rdata}) $display("[TB] FAIL readback_%0d: got v/e/d %b/%b/%h expected 1/%b/%h", k, got, er, rd, e.err, e.rdata); else passCount++;
    end
  endtask

  task automatic test_illegal();
    int acc, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    bit          cw [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] ca [3] = '{16'h0200, 16'h0006, 16'h0020};
    logic [3:0]  cs [3] = '{4'h0, 4'h0, 4'h3};
    for (int k = 0; k < 3; k++) begin
      issue(cw[k], ca[k], 32'h1234_5678, cs[k], acc, enS, weS, adS, dinS, ok);
      collect(got, rc, rd, er);
      popExp(e, have);
      checkCount++; if (enS !== 1'b0) $display("[TB] FAIL illegal_%0d_en: got %b expected 0", k, enS); else passCount++;
      checkCount++; if ({got, er, rd} !== {1'b1, 1'b1, 32'h0}) $display("[TB] FAIL illegal_%0d_rsp: got v/e/d %b/%b/%h expected 1/1/0", k, got, er, rd); else passCount++;
      checkCount++; if (rc - acc !== e.lat) $display("[TB] FAIL illegal_%0d_latency: got %0d expected %0d", k, rc - acc, e.lat); else passCount++;
    end
    // The rejected partial write must not have touched word 8.
    issue(1'b0, 16'h0020, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, rd} !== {1'b1, e.rdata}) $display("[TB] FAIL illegal_no_write: got %b/%h expected 1/%h", got, rd, e.rdata); else passCount++;
  endtask

  task automatic test_backpressure();
    int acc, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    rsp_ready_i = 1'b0;
    issue(1'b0, 16'h0014, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, rd} !== {1'b1, e.rdata}) $display("[TB] FAIL bp_first: got %b/%h expected 1/%h", got, rd, e.rdata); else passCount++;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 16'h0018;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      checkCount++;
      if ({rsp_valid_o, rsp_rdata_o, rsp_error_o, req_ready_o, en_o} !== {1'b1, e.rdata, 1'b0, 1'b0, 1'b0})
        $display("[TB] FAIL bp_hold_%0d: got v/d/e/rr/en %b/%h/%b/%b/%b expected 1/%h/0/0/0", i, rsp_valid_o, rsp_rdata_o, rsp_error_o, req_ready_o, en_o, e.rdata);
      else passCount++;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkCount++; if ({rsp_valid_o, rsp_rdata_o} !== 33'h0) $display("[TB] FAIL bp_release: got %b/%h expected 0/0", rsp_valid_o, rsp_rdata_o); else passCount++;
    // Converter not ready: request must wait in IDLE without issuing.
    ready_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkCount++; if ({req_ready_o, en_o} !== 2'b00) $display("[TB] FAIL bp_conv_stall_%0d: got rr/en %b/%b expected 0/0", i, req_ready_o, en_o); else passCount++;
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    issue(1'b0, 16'h0010, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({enS, adS, got, rd} !== {1'b1, 7'd4, 1'b1, e.rdata}) $display("[TB] FAIL bp_conv_resume: got en/addr/v/d %b/%0d/%b/%h expected 1/4/1/%h", enS, adS, got, rd, e.rdata); else passCount++;
  endtask

  task automatic test_fault();
    int acc, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    faultNext = 1'b1;
    issue(1'b0, 16'h0014, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    faultNext = 1'b0;
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, er, rd} !== {1'b1, 1'b1, 32'h0}) $display("[TB] FAIL fault_rsp: got v/e/d %b/%b/%h expected 1/1/0", got, er, rd); else passCount++;
    checkCount++; if (rc - acc !== e.lat) $display("[TB] FAIL fault_latency: got %0d expected %0d", rc - acc, e.lat); else passCount++;
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    issue(1'b0, 16'h0000, 32'h0, 4'h0, acc1, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, er, rd} !== {1'b1, e.err, e.rdata}) $display("[TB] FAIL b2b_rsp_a: got %b/%b/%h expected 1/%b/%h", got, er, rd, e.err, e.rdata); else passCount++;
    issue(1'b0, 16'h0004, 32'h0, 4'h0, acc2, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, er, rd} !== {1'b1, e.err, e.rdata}) $display("[TB] FAIL b2b_rsp_b: got %b/%b/%h expected 1/%b/%h", got, er, rd, e.err, e.rdata); else passCount++;
    checkCount++; if (acc2 - acc1 !== 3) $display("[TB] FAIL b2b_legal_spacing: got %0d expected 3", acc2 - acc1); else passCount++;
    issue(1'b0, 16'h0301, 32'h0, 4'h0, acc1, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    issue(1'b0, 16'h0002, 32'h0, 4'h0, acc2, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, er} !== 2'b11) $display("[TB] FAIL b2b_illegal_rsp: got %b/%b expected 1/1", got, er); else passCount++;
    checkCount++; if (acc2 - acc1 !== 2) $display("[TB] FAIL b2b_illegal_spacing: got %0d expected 2", acc2 - acc1); else passCount++;
  endtask

  task automatic test_reset_mid();
    int acc, rc; logic enS, weS, er; logic [6:0] adS; logic [31:0] dinS, rd; bit ok, got, have; exp_t e;
    // Reset while in WAIT.
    issue(1'b0, 16'h0014, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    popExp(e, have);
    #2 rst_ni = 1'b0; #1;
    checkCount++; if ({rsp_valid_o, rsp_error_o, rsp_rdata_o, en_o} !== 35'h0) $display("[TB] FAIL rst_wait_outputs: got v/e/d/en %b/%b/%h/%b expected all 0", rsp_valid_o, rsp_error_o, rsp_rdata_o, en_o); else passCount++;
    checkCount++; if (req_ready_o !== 1'b1) $display("[TB] FAIL rst_wait_req_ready: got %b expected 1", req_ready_o); else passCount++;
    @(negedge clk_i) rst_ni = 1'b1;
    issue(1'b0, 16'h01FC, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, er, rd} !== {1'b1, 1'b0, 32'hA5A5_0001}) $display("[TB] FAIL rst_wait_recover: got %b/%b/%h expected 1/0/A5A50001", got, er, rd); else passCount++;
    // Reset while holding a response in RESP.
    rsp_ready_i = 1'b0;
    issue(1'b0, 16'h0014, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hDEADBEEF}) $display("[TB] FAIL rst_resp_pre: got %b/%h expected 1/DEADBEEF", rsp_valid_o, rsp_rdata_o); else passCount++;
    #2 rst_ni = 1'b0; #1;
    checkCount++; if ({rsp_valid_o, rsp_error_o, rsp_rdata_o} !== 34'h0) $display("[TB] FAIL rst_resp_outputs: got v/e/d %b/%b/%h expected all 0", rsp_valid_o, rsp_error_o, rsp_rdata_o); else passCount++;
    @(negedge clk_i) rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    issue(1'b0, 16'h0010, 32'h0, 4'h0, acc, enS, weS, adS, dinS, ok);
    collect(got, rc, rd, er);
    popExp(e, have);
    checkCount++; if ({got, er, rd} !== {1'b1, 1'b0, e.rdata}) $display("[TB] FAIL rst_resp_recover: got %b/%b/%h expected 1/0/%h", got, er, rd, e.rdata); else passCount++;
    checkCount++; if (rc - acc !== 2) $display("[TB] FAIL rst_resp_latency: got %0d expected 2", rc - acc); else passCount++;
  endtask

  initial begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      convMem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      refMem[i]  = 32'h1000_0000 + 32'(i) * 32'h0101;
    end
    convMem[5] = 32'hDEADBEEF;
    refMem[5]  = 32'hDEADBEEF;
    test_reset();
    test_read_hit();
    test_write_readback();
    test_illegal();
    test_backpressure();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
